// File: rtl/cdb_arbiter_if.sv
// Request and broadcast signals between the execution units and the CDB arbiter.
// The arbiter takes the slave modport; the units/bench side takes master.
interface cdb_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int ROB_WIDTH = 4
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag;
  logic [N_REQ-1:0][31:0]          req_data;
  logic [N_REQ-1:0]                req_ready;
  logic                            flush;
  logic                            cdb_valid;
  logic [ROB_WIDTH-1:0]            cdb_tag;
  logic [31:0]                     cdb_data;
  logic [IDX_W-1:0]                grant_idx;

  modport master (
    output req_valid, req_tag, req_data, flush,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, grant_idx
  );

  modport slave (
    input  req_valid, req_tag, req_data, flush,
    output req_ready, cdb_valid, cdb_tag, cdb_data, grant_idx
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one grant per cycle, registered
// broadcast of the winner's ROB tag and data, and a flush that cancels grants.
module cdb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ROB_WIDTH = 4
) (
  input logic           clk,
  input logic           rstn,
  cdb_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W-1:0]     idx;
  logic [N_REQ-1:0]     grant;
  logic                 found;
  logic                 cdb_valid;
  logic [ROB_WIDTH-1:0] cdb_tag;
  logic [31:0]          cdb_data;
  logic [IDX_W-1:0]     grant_idx;

  // Search starts one past the previous winner; rstn is in the path so that a
  // grant seen while reset is asserted never looks like a transfer.
  always_comb begin
    grant = '0;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    if (rstn && !bus.flush) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = IDX_W'((int'(last) + k) % N_REQ);
        if (!found && bus.req_valid[idx]) begin
          found      = 1'b1;
          sel        = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;

  // last resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      grant_idx <= '0;
      last      <= IDX_W'(N_REQ - 1);
    end else begin
      cdb_valid <= found;
      if (found) begin
        cdb_tag   <= bus.req_tag[sel];
        cdb_data  <= bus.req_data[sel];
        grant_idx <= sel;
        last      <= sel;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid;
  assign bus.cdb_tag   = cdb_tag;
  assign bus.cdb_data  = cdb_data;
  assign bus.grant_idx = grant_idx;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter: a round-robin model predicts each grant and
// queues the broadcast it implies; the queue is drained against the CDB.
module tb_cdb_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [1:0]  idx;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_last = N - 1;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N), .ROB_WIDTH(4)) bus ();

  cdb_arbiter #(.N_REQ(N), .ROB_WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int lst,
                                             input logic fl, input logic rs);
    logic [3:0] g;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (lst + k) % N;
      if (rs && !fl && g == 4'b0000 && v[j]) g[j] = 1'b1;
    end
    return g;
  endfunction

  // Predict this edge's grant, queue the resulting broadcast, then step a clock.
  task automatic advance();
    logic [3:0] g;
    exp_t e;
    g = model_grant(bus.req_valid, model_last, bus.flush, rstn);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        e.tag  = bus.req_tag[i];
        e.data = bus.req_data[i];
        e.idx  = 2'(i);
        exp_q.push_back(e);
        model_last = i;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    exp_q.delete();
    model_last = N - 1;
  endtask

  task automatic test_reset();
    logic ev;
    exp_t e;
    rstn = 1'b0;
    bus.flush = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      bus.req_tag[i]  = 4'(i + 1);
      bus.req_data[i] = 32'h1000 + i;
    end
    #2;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, expected 0000", bus.req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_cdb: got v=%b tag=%0d data=%h idx=%0d, expected all zero",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: got %b, expected 0001", bus.req_ready);
    end
    advance();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      ev = (exp_q.size() != 0);
      if (ev) e = exp_q.pop_front(); else e = '0;
      checks++;
      if (bus.cdb_valid !== ev || (ev && {bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== {e.tag, e.data, e.idx})) begin
        errors++;
        $display("[TB] FAIL reset_cdb_%0d: got v=%b tag=%0d data=%h idx=%0d, expected v=%b tag=%0d data=%h idx=%0d",
                 c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx, ev, e.tag, e.data, e.idx);
      end
      if (c == 0) advance();
    end
  endtask

  task automatic test_single();
    logic ev;
    exp_t e;
    bus.req_valid   = 4'b0100;
    bus.req_tag[2]  = 4'd5;
    bus.req_data[2] = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b, expected 0100", bus.req_ready);
    end
    for (int c = 0; c < 2; c++) begin
      advance();
      bus.req_valid = 4'b0000;
      ev = (exp_q.size() != 0);
      if (ev) e = exp_q.pop_front(); else e = '0;
      checks++;
      if (bus.cdb_valid !== ev || (ev && {bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== {e.tag, e.data, e.idx})) begin
        errors++;
        $display("[TB] FAIL single_cdb_%0d: got v=%b tag=%0d data=%h idx=%0d, expected v=%b tag=%0d data=%h idx=%0d",
                 c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx, ev, e.tag, e.data, e.idx);
      end
    end
  endtask

  task automatic test_fairness();
    logic ev;
    exp_t e;
    int idx;
    pulse_reset();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (c < 8) begin
        checks++;
        if (bus.req_ready !== (4'b0001 << (c % N))) begin
          errors++;
          $display("[TB] FAIL fair_ready_%0d: got %b, expected %b", c, bus.req_ready, 4'b0001 << (c % N));
        end
      end else begin
        bus.req_valid = 4'b0000;
      end
      advance();
      ev = (exp_q.size() != 0);
      if (ev) e = exp_q.pop_front(); else e = '0;
      checks++;
      if (bus.cdb_valid !== (c < 8) || bus.cdb_valid !== ev ||
          (ev && {bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== {e.tag, e.data, e.idx})) begin
        errors++;
        $display("[TB] FAIL fair_cdb_%0d: got v=%b tag=%0d data=%h idx=%0d, expected v=%b tag=%0d data=%h idx=%0d",
                 c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx, ev, e.tag, e.data, e.idx);
      end
      idx = c % N;
      bus.req_tag[idx]  = 4'($urandom_range(0, 15));
      bus.req_data[idx] = $urandom;
    end
  endtask

  task automatic test_skip_idle();
    logic ev;
    exp_t e;
    logic [3:0] vpat [4];
    logic [3:0] rpat [4];
    vpat = '{4'b0010, 4'b0001, 4'b1111, 4'b0000};
    rpat = '{4'b0010, 4'b0001, 4'b0010, 4'b0000};
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = vpat[c];
      #1;
      checks++;
      if (bus.req_ready !== rpat[c]) begin
        errors++;
        $display("[TB] FAIL skip_ready_%0d: got %b, expected %b", c, bus.req_ready, rpat[c]);
      end
      advance();
      ev = (exp_q.size() != 0);
      if (ev) e = exp_q.pop_front(); else e = '0;
      checks++;
      if (bus.cdb_valid !== ev || (ev && {bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== {e.tag, e.data, e.idx})) begin
        errors++;
        $display("[TB] FAIL skip_cdb_%0d: got v=%b tag=%0d data=%h idx=%0d, expected v=%b tag=%0d data=%h idx=%0d",
                 c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx, ev, e.tag, e.data, e.idx);
      end
    end
  endtask

  task automatic test_flush();
    logic ev;
    exp_t e;
    logic       fpat [4];
    logic [3:0] rpat [4];
    fpat = '{1'b0, 1'b1, 1'b0, 1'b0};
    rpat = '{4'b1000, 4'b0000, 4'b0010, 4'b0000};
    bus.req_tag[1]  = 4'd7;
    bus.req_data[1] = 32'h0000_0711;
    bus.req_tag[3]  = 4'd11;
    bus.req_data[3] = 32'h0000_0B33;
    for (int c = 0; c < 4; c++) begin
      bus.flush     = fpat[c];
      bus.req_valid = (c == 3) ? 4'b0000 : 4'b1010;
      if (c == 1) begin
        bus.req_tag[3]  = 4'd12;
        bus.req_data[3] = 32'h0000_0C44;
        checks++;
        if (bus.cdb_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL flush_visible: got cdb_valid=%b, expected 1", bus.cdb_valid);
        end
      end
      #1;
      checks++;
      if (bus.req_ready !== rpat[c]) begin
        errors++;
        $display("[TB] FAIL flush_ready_%0d: got %b, expected %b", c, bus.req_ready, rpat[c]);
      end
      advance();
      ev = (exp_q.size() != 0);
      if (ev) e = exp_q.pop_front(); else e = '0;
      checks++;
      if (bus.cdb_valid !== ev || (ev && {bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== {e.tag, e.data, e.idx})) begin
        errors++;
        $display("[TB] FAIL flush_cdb_%0d: got v=%b tag=%0d data=%h idx=%0d, expected v=%b tag=%0d data=%h idx=%0d",
                 c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx, ev, e.tag, e.data, e.idx);
      end
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_stability();
    logic ev;
    exp_t e;
    logic [3:0] g;
    int cycles;
    logic got3;
    got3 = 1'b0;
    cycles = 0;
    bus.req_valid   = 4'b1111;
    bus.req_tag[3]  = 4'd9;
    bus.req_data[3] = 32'hCAFEF00D;
    while (!got3 && cycles < 5) begin
      #1;
      g = model_grant(bus.req_valid, model_last, bus.flush, rstn);
      checks++;
      if (bus.req_ready !== g) begin
        errors++;
        $display("[TB] FAIL stab_ready_%0d: got %b, expected %b", cycles, bus.req_ready, g);
      end
      advance();
      cycles++;
      ev = (exp_q.size() != 0);
      if (ev) e = exp_q.pop_front(); else e = '0;
      checks++;
      if (bus.cdb_valid !== ev || (ev && {bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== {e.tag, e.data, e.idx})) begin
        errors++;
        $display("[TB] FAIL stab_cdb_%0d: got v=%b tag=%0d data=%h idx=%0d, expected v=%b tag=%0d data=%h idx=%0d",
                 cycles, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx, ev, e.tag, e.data, e.idx);
      end
      if (g[3]) begin
        got3 = 1'b1;
        bus.req_valid[3] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (g[i]) begin
          bus.req_tag[i]  = 4'($urandom_range(0, 15));
          bus.req_data[i] = $urandom;
        end
      end
    end
    checks++;
    if (!got3 || cycles > 3 || bus.cdb_tag !== 4'd9 || bus.cdb_data !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL stab_wait: got granted=%b after %0d cycles tag=%0d data=%h, expected granted within 3 tag=9 data=cafef00d",
               got3, cycles, bus.cdb_tag, bus.cdb_data);
    end
    bus.req_valid = 4'b0000;
    advance();
  endtask

  task automatic test_reset_mid();
    logic ev;
    exp_t e;
    exp_q.delete();
    bus.req_valid = 4'b1111;
    #1;
    advance();
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_ready: got %b, expected 0000", bus.req_ready);
    end
    checks++;
    if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_cdb: got v=%b tag=%0d data=%h idx=%0d, expected all zero",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx);
    end
    exp_q.delete();
    model_last = N - 1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midreset_first_grant: got %b, expected 0001", bus.req_ready);
    end
    advance();
    ev = (exp_q.size() != 0);
    if (ev) e = exp_q.pop_front(); else e = '0;
    checks++;
    if (bus.cdb_valid !== ev || (ev && {bus.cdb_tag, bus.cdb_data, bus.grant_idx} !== {e.tag, e.data, e.idx})) begin
      errors++;
      $display("[TB] FAIL midreset_cdb_after: got v=%b tag=%0d data=%h idx=%0d, expected v=%b tag=%0d data=%h idx=%0d",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.grant_idx, ev, e.tag, e.data, e.idx);
    end
    bus.req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_skip_idle();
    test_flush();
    test_stability();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got no completion by 200000, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB) of the out-of-order core. It collects result broadcasts from N_REQ execution units (ALU, FPU, load/store, in/out) and grants at most one per cycle. It drives a registered CDB of the `cdb_t` layout (valid, ROB tag, 32-bit data) to the reservation stations, register file and ROB. It also supports a misprediction flush that discards any broadcast in flight.

## Interface
- `N_REQ`, default 4: number of requesting execution units (2..8).
- `ROB_WIDTH`, default 4: ROB tag width; taken from `my_package`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i holds a result.
- `req_tag`  in  N_REQ×ROB_WIDTH  ROB tag per requester.
- `req_data`  in  N_REQ×32  result data per requester.
- `req_ready`  out  N_REQ  one-hot or zero grant to requesters; combinational.
- `flush`  in  1  misprediction flush from commit.
- `cdb_valid`  out  1  CDB broadcast valid; registered.
- `cdb_tag`  out  ROB_WIDTH  CDB tag; registered.
- `cdb_data`  out  32  CDB data; registered.
- `grant_idx`  out  clog2(N_REQ)  index of the requester whose result is on the CDB; registered, for debug/perf.

## Operation
**Handshake**
- Requester i transfers when `req_valid[i] && req_ready[i]` at a rising edge.
- Once raised, a requester holds `req_valid`, tag and data stable until it sees `req_ready`.
- The arbiter never raises `req_ready[i]` while `req_valid[i]` is 0.

**Arbitration**
- State is `last` (clog2(N_REQ) bits), the index of the most recent grant.
- Search order is `last+1, last+2, …` modulo N_REQ; the first valid requester is granted.
- `last` updates to the granted index on every transfer. It is unchanged when nothing is granted.
- Wrap-around: if `last` = N_REQ-1, search starts at 0.

**CDB register**
- On transfer: `cdb_valid`←1, `cdb_tag`/`cdb_data`←granted requester's values, `grant_idx`←granted index.
- With no transfer: `cdb_valid`←0. `cdb_tag`, `cdb_data` and `grant_idx` hold their old values.
- The CDB is never back-pressured; every valid cycle is one broadcast.

**Flush**
- While `flush`=1, `req_ready` is all 0.
- On the edge where `flush`=1, `cdb_valid`←0, even if a broadcast was pending.
- `last` is unchanged by a flush.
- Requesters are responsible for dropping their own `req_valid` (their units flush too).
- The CDB value registered in the cycle before flush is still visible during the flush cycle; consumers gate it with their own flush.

**Reset**
- `rstn`=0 asynchronously forces: `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0, `grant_idx`=0, `last`=N_REQ-1 (so requester 0 has top priority first), `req_ready`=0.
- Reset mid-transfer drops the broadcast. A requester whose `req_ready` was high in the cycle reset asserted must not consider itself accepted.

## Timing
- `req_ready` is combinational from `req_valid`, `flush`, `last` and `rstn`, with no combinational path from `req_tag`/`req_data`.
- Latency is 1 cycle: a result accepted at edge k is on the CDB during cycle k+1 (`cdb_valid` high for exactly one cycle per transfer).
- Throughput is 1 broadcast per cycle in total.
- With all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles (no starvation, worst-case wait N_REQ-1 cycles).
- When `flush` and `req_valid` are both high in the same cycle, flush wins: no grant and no CDB valid on the next cycle.
- Deassertion of `rstn` is synchronized externally; the first grant may occur at the first edge after release.

## Test plan
- **Reset values:** assert `rstn`=0 mid-run with `req_valid`=4'b1111 → `req_ready`=0 immediately, `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0; after release, first grant goes to requester 0.
- **Single request:** `req_valid`=4'b0100 with tag 5, data 32'hDEADBEEF → `req_ready`=4'b0100 in the same cycle; next cycle `cdb_valid`=1, `cdb_tag`=5, `cdb_data`=32'hDEADBEEF, `grant_idx`=2; the cycle after, `cdb_valid`=0.
- **Fairness/wrap:** all four valid for 8 cycles, each re-raising after a grant → grant order 0,1,2,3,0,1,2,3; `cdb_valid` high on all 8 consecutive following cycles.
- **Skip idle:** `last`=1, `req_valid`=4'b0001 → requester 0 is granted (wrap past 2,3); `last` becomes 0.
- **Flush:** `flush`=1 with `req_valid`=4'b1010 → `req_ready`=0, next-cycle `cdb_valid`=0, `last` unchanged; after flush drops, the next grant follows the old order.
- **Stability:** requester 3 is held valid while 0–2 are continuously valid → requester 3 is granted within 3 cycles, with tag and data unchanged on the CDB.
